// File: rtl/matinv_pkg.sv
// -----------------------------------------------------------------------------
// matinv_pkg
// Shared types and helpers for the matinv_check inverse-checker slice.
//   state_t    : checker FSM states (IDLE / MAC / CMP / DONE)
//   acc_width  : accumulator width that cannot overflow for an N-term dot product
//   elem_idx   : row-major element index of (r,c) in a packed NxN matrix
//   one_fx     : fixed-point 1.0 for a given number of fractional bits
// -----------------------------------------------------------------------------
package matinv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Product of two W-bit signed values is 2W bits; summing N of them adds clog2(N).
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  function automatic longint one_fx(input int bin_pos);
    return longint'(1) << bin_pos;
  endfunction

endpackage

// File: rtl/matinv_check_if.sv
// -----------------------------------------------------------------------------
// matinv_check_if
// Request/result bus between a matrix-inverse producer and matinv_check.
//   Request : i_valid, o_ready, i_matrix, i_inv, i_singular
//   Result  : o_valid, i_ready, o_pass, o_singular, o_max_err
//   Optional: o_err_row, o_err_col (only with MATINV_CHECK_ERRPOS_EN defined)
// Modports: master = producer/consumer side, slave = checker side.
// -----------------------------------------------------------------------------
interface matinv_check_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 3
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = MATRIX_SIZE;
  localparam int EW = (N > 1) ? $clog2(N) : 1;

  logic              i_valid;
  logic              o_ready;
  logic [N*N*W-1:0]  i_matrix;
  logic [N*N*W-1:0]  i_inv;
  logic              i_singular;
  logic              o_valid;
  logic              i_ready;
  logic              o_pass;
  logic              o_singular;
  logic [W-1:0]      o_max_err;
`ifdef MATINV_CHECK_ERRPOS_EN
  logic [EW-1:0]     o_err_row;
  logic [EW-1:0]     o_err_col;
`endif

  modport master (
`ifdef MATINV_CHECK_ERRPOS_EN
    input  o_err_row, o_err_col,
`endif
    output i_valid, i_matrix, i_inv, i_singular, i_ready,
    input  o_ready, o_valid, o_pass, o_singular, o_max_err
  );

  modport slave (
`ifdef MATINV_CHECK_ERRPOS_EN
    output o_err_row, o_err_col,
`endif
    input  i_valid, i_matrix, i_inv, i_singular, i_ready,
    output o_ready, o_valid, o_pass, o_singular, o_max_err
  );

endinterface

// File: rtl/matinv_mac.sv
// -----------------------------------------------------------------------------
// matinv_mac
// Signed W x W multiply-accumulate into an AW-bit accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : accumulate a_i*b_i this cycle
//   a_i, b_i : signed operands
//   acc_o    : current accumulator value
// -----------------------------------------------------------------------------
module matinv_mac #(
  parameter int W  = 32,
  parameter int AW = 66
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [W-1:0]  a_i,
  input  logic signed [W-1:0]  b_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AW'(prod);  // signed size cast sign-extends the product
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matinv_check.sv
// -----------------------------------------------------------------------------
// matinv_check
// Checks a claimed matrix inverse: forms P = A*inv one element at a time
// (row-major, N MAC cycles + 1 compare cycle per element) and reports whether
// every |P[r][c] - I[r][c]| is within TOL LSBs.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : matinv_check_if.slave (request, result, optional error position)
// Optional feature: define MATINV_CHECK_ERRPOS_EN to add o_err_row/o_err_col,
// the position of the element that set o_max_err.
// -----------------------------------------------------------------------------
module matinv_check
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3,
  parameter int TOL         = 4
) (
  input  logic          clk,
  input  logic          rst,
  matinv_check_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = MATRIX_SIZE;
  localparam int AW = acc_width(W, N);
  localparam int MW = N * N * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(MW);
  localparam logic signed [AW:0] ONE_V = (AW+1)'(one_fx(BIN_POS));

  state_t             state_q;
  logic [MW-1:0]      mat_q, inv_q;
  logic [CW-1:0]      r_q, c_q, k_q;
  logic               ready_q, valid_q, pass_q, singular_q;
  logic [W-1:0]       max_err_q, max_err_d;
`ifdef MATINV_CHECK_ERRPOS_EN
  logic [CW-1:0]      err_row_q, err_col_q;
`endif

  logic [IW-1:0]      a_idx, b_idx;
  logic signed [W-1:0]  a_op, b_op;
  logic signed [AW-1:0] acc;
  logic signed [AW:0]   acc_ext, p_val, ref_v, diff;
  logic [AW:0]        abs_e;
  logic [W-1:0]       err_sat;
  logic               err_gt, last_elem;

  // Operand muxes: A[r][k] and inv[k][c].
  always_comb begin
    a_idx = IW'(elem_idx(int'(r_q), int'(k_q), N) * W);
    b_idx = IW'(elem_idx(int'(k_q), int'(c_q), N) * W);
  end
  assign a_op = mat_q[a_idx +: W];
  assign b_op = inv_q[b_idx +: W];

  matinv_mac #(.W(W), .AW(AW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_CMP),
    .en_i  (state_q == ST_MAC),
    .a_i   (a_op),
    .b_i   (b_op),
    .acc_o (acc)
  );

  // Error of the current element; one spare bit keeps the subtraction exact.
  always_comb begin
    acc_ext   = {acc[AW-1], acc};
    p_val     = acc_ext >>> BIN_POS;       // floor toward -inf
    ref_v     = (r_q == c_q) ? ONE_V : '0;
    diff      = p_val - ref_v;
    abs_e     = diff[AW] ? -diff : diff;
    err_sat   = (|abs_e[AW:W]) ? '1 : abs_e[W-1:0];
    err_gt    = err_sat > max_err_q;       // strict: earliest element keeps ties
    max_err_d = err_gt ? err_sat : max_err_q;
    last_elem = (r_q == CW'(N-1)) && (c_q == CW'(N-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mat_q      <= '0;
      inv_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      pass_q     <= 1'b0;
      singular_q <= 1'b0;
      max_err_q  <= '0;
`ifdef MATINV_CHECK_ERRPOS_EN
      err_row_q  <= '0;
      err_col_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_valid && ready_q) begin
            mat_q      <= bus.i_matrix;
            inv_q      <= bus.i_inv;
            singular_q <= bus.i_singular;
            ready_q    <= 1'b0;
            pass_q     <= 1'b0;
            max_err_q  <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
`ifdef MATINV_CHECK_ERRPOS_EN
            err_row_q  <= '0;
            err_col_q  <= '0;
`endif
            if (bus.i_singular) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_MAC;
            end
          end
        end
        ST_MAC: begin
          if (k_q == CW'(N-1)) begin
            k_q     <= '0;
            state_q <= ST_CMP;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        ST_CMP: begin
          max_err_q <= max_err_d;
`ifdef MATINV_CHECK_ERRPOS_EN
          if (err_gt) begin
            err_row_q <= r_q;
            err_col_q <= c_q;
          end
`endif
          if (last_elem) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            pass_q  <= !singular_q && (max_err_d <= W'(TOL));
          end else begin
            state_q <= ST_MAC;
            if (c_q == CW'(N-1)) begin
              c_q <= '0;
              r_q <= r_q + CW'(1);
            end else begin
              c_q <= c_q + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_pass     = pass_q;
  assign bus.o_singular = singular_q;
  assign bus.o_max_err  = max_err_q;
`ifdef MATINV_CHECK_ERRPOS_EN
  assign bus.o_err_row  = err_row_q;
  assign bus.o_err_col  = err_col_q;
`endif

endmodule

// File: tb/tb_matinv_check.sv
// -----------------------------------------------------------------------------
// tb_matinv_check
// Self-checking bench for matinv_check (N=3, W=32, BIN_POS=16, TOL=4).
// Directed cases plus randomized requests, scored against a dot-product model.
// -----------------------------------------------------------------------------
module tb_matinv_check;

  localparam int W   = 32;
  localparam int N   = 3;
  localparam int BP  = 16;
  localparam int TOL = 4;
  localparam int MW  = N * N * W;
  localparam int LAT = N * N * (N + 1);
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matinv_check_if #(.DATA_WIDTH(W), .MATRIX_SIZE(N)) bus ();

  matinv_check #(
    .DATA_WIDTH (W),
    .BIN_POS    (BP),
    .MATRIX_SIZE(N),
    .TOL        (TOL)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- matrix helpers / reference model ----------------
  function automatic longint el(input logic [MW-1:0] m, input int r, input int c);
    logic signed [W-1:0] t;
    t = m[(r*N+c)*W +: W];
    return longint'(t);
  endfunction

  function automatic logic [MW-1:0] set_el(input logic [MW-1:0] m, input int r,
                                           input int c, input logic [W-1:0] v);
    m[(r*N+c)*W +: W] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] diag(input logic [W-1:0] v);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m = set_el(m, i, i, v);
    return m;
  endfunction

  // P = A*B in plain integer arithmetic, floor-shifted, compared to identity.
  task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic sing,
                       output logic pass, output logic [W-1:0] mx,
                       output int er, output int ec);
    longint s, p, e, sat;
    sat  = 64'h0000_0000_FFFF_FFFF;
    mx   = '0;
    er   = 0;
    ec   = 0;
    pass = 1'b0;
    if (!sing) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          s = 0;
          for (int k = 0; k < N; k++) s += el(a, r, k) * el(b, k, c);
          p = s >>> BP;
          e = p - ((r == c) ? (longint'(1) << BP) : longint'(0));
          if (e < 0) e = -e;
          if (e > sat) e = sat;
          if (e > longint'(mx)) begin
            mx = e[W-1:0];
            er = r;
            ec = c;
          end
        end
      end
      pass = (mx <= 32'(TOL));
    end
  endtask

  // ---------------- one full request/response ----------------
  task automatic run_req(input string nm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic sing, input int hold);
    logic          pass_e;
    logic [W-1:0]  mx_e;
    int            er_e, ec_e, lat;
    bit            got;
    model(a, b, sing, pass_e, mx_e, er_e, ec_e);

    @(negedge clk);
    chk({nm, ".idle_ready"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid    = 1'b1;
    bus.i_matrix   = a;
    bus.i_inv      = b;
    bus.i_singular = sing;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk({nm, ".busy_ready"}, 64'(bus.o_ready), 64'd0);
    if (!sing) chk({nm, ".early_valid"}, 64'(bus.o_valid), 64'd0);

    got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.o_valid) got = 1'b1;
    end
    chk({nm, ".latency"}, 64'(got ? lat : -1), 64'(sing ? 1 : LAT));
    chk({nm, ".pass"},     64'(bus.o_pass),     64'(pass_e));
    chk({nm, ".singular"}, 64'(bus.o_singular), 64'(sing));
    chk({nm, ".max_err"},  64'(bus.o_max_err),  64'(mx_e));
`ifdef MATINV_CHECK_ERRPOS_EN
    chk({nm, ".err_row"},  64'(bus.o_err_row),  64'(er_e));
    chk({nm, ".err_col"},  64'(bus.o_err_col),  64'(ec_e));
`endif

    // Stall the result while offering a new request; nothing may move.
    for (int i = 0; i < hold; i++) begin
      bus.i_valid    = 1'b1;
      bus.i_matrix   = {9{$urandom()}};
      bus.i_singular = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".hold_valid"},   64'(bus.o_valid),   64'd1);
      chk({nm, ".hold_ready"},   64'(bus.o_ready),   64'd0);
      chk({nm, ".hold_max_err"}, 64'(bus.o_max_err), 64'(mx_e));
      chk({nm, ".hold_pass"},    64'(bus.o_pass),    64'(pass_e));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk({nm, ".post_valid"}, 64'(bus.o_valid), 64'd0);
    chk({nm, ".post_ready"}, 64'(bus.o_ready), 64'd1);
    $display("txn %s: sing=%0d pass=%0d max_err=%0h lat=%0d", nm, sing, bus.o_pass,
             bus.o_max_err, lat);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".ready"},    64'(bus.o_ready),    64'd1);
    chk({nm, ".valid"},    64'(bus.o_valid),    64'd0);
    chk({nm, ".pass"},     64'(bus.o_pass),     64'd0);
    chk({nm, ".singular"}, 64'(bus.o_singular), 64'd0);
    chk({nm, ".max_err"},  64'(bus.o_max_err),  64'd0);
`ifdef MATINV_CHECK_ERRPOS_EN
    chk({nm, ".err_row"},  64'(bus.o_err_row),  64'd0);
    chk({nm, ".err_col"},  64'(bus.o_err_col),  64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] a, b, ident;
    int            kind, s, r, c;
    longint        v;

    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_singular = 1'b0;
    bus.i_matrix   = '0;
    bus.i_inv      = '0;
    ident          = diag(ONE);

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_req("identity", ident, ident, 1'b0, 0);
    run_req("diag_scale", diag(32'h0002_0000), diag(32'h0000_8000), 1'b0, 0);
    run_req("offdiag_err", ident, set_el(ident, 0, 1, 32'h10), 1'b0, 0);
    run_req("singular", ident, ident, 1'b1, 0);
    run_req("stall", ident, set_el(ident, 2, 0, 32'h3), 1'b0, 10);

    // Reset in the middle of a computation.
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_matrix   = ident;
    bus.i_inv      = set_el(ident, 1, 1, 32'h0001_0100);
    bus.i_singular = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort_async");
    @(negedge clk);
    chk_reset_outputs("abort_held");
    rst = 1'b0;
    $display("txn abort: reset applied mid-computation");
    run_req("rerun_identity", ident, ident, 1'b0, 0);

    // Randomized requests.
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 3);
      a = '0;
      b = '0;
      if (kind <= 1) begin
        // Exact inverse pair of scaled diagonals, then small perturbations.
        s = $urandom_range(0, 3);
        a = diag(32'(1) << (BP + s));
        b = diag(32'(1) << (BP - s));
        for (int j = 0; j < 2; j++) begin
          r = $urandom_range(0, N-1);
          c = $urandom_range(0, N-1);
          v = el(b, r, c) + longint'(int'($urandom_range(0, 4)) - 2);
          b = set_el(b, r, c, v[W-1:0]);
        end
        run_req($sformatf("rnd_near%0d", t), a, b, 1'b0, $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            v = longint'($urandom_range(0, 32'h2000_0000)) - 64'sh1000_0000;
            a = set_el(a, i, j, v[W-1:0]);
            v = longint'($urandom_range(0, 32'h2000_0000)) - 64'sh1000_0000;
            b = set_el(b, i, j, v[W-1:0]);
          end
        end
        run_req($sformatf("rnd_full%0d", t), a, b, (kind == 3), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
